// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        STALL = 2'd2
    } fetch_state_e;

    localparam int INSTR_BYTES = 4;
    localparam int QDEPTH      = 2;

    typedef struct packed {
        logic [31:0] instr;
        logic [63:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Two-entry instruction queue. The head entry is a dedicated register, so the
// delivered Instr/InstrPC are registered and keep their last value when empty.
module fetch_queue
    import fetch_pkg::*;
(
    input  logic        CLK,
    input  logic        Reset_L,
    input  logic        push_i,
    input  logic        pop_i,
    input  logic        flush_i,
    input  logic [31:0] din_instr_i,
    input  logic [63:0] din_pc_i,
    output logic        full_o,
    output logic        empty_o,
    output logic [31:0] head_instr_o,
    output logic [63:0] head_pc_o
);

    fetch_entry_t head_q;
    fetch_entry_t tail_q;
    logic [1:0]   count_q;
    fetch_entry_t din;

    assign din.instr    = din_instr_i;
    assign din.pc       = din_pc_i;
    assign full_o       = (count_q == 2'(QDEPTH));
    assign empty_o      = (count_q == 2'd0);
    assign head_instr_o = head_q.instr;
    assign head_pc_o    = head_q.pc;

    // Shift-style FIFO: pops move the tail into the head, pushes fill the first free slot.
    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
        end else if (flush_i) begin
            count_q <= 2'd0;
        end else begin
            case (count_q)
                2'd0: begin
                    if (push_i) begin
                        head_q  <= din;
                        count_q <= 2'd1;
                    end
                end
                2'd1: begin
                    if (push_i && pop_i) begin
                        head_q <= din;
                    end else if (push_i) begin
                        tail_q  <= din;
                        count_q <= 2'd2;
                    end else if (pop_i) begin
                        count_q <= 2'd0;
                    end
                end
                default: begin
                    if (pop_i) begin
                        head_q <= tail_q;
                        if (push_i) begin
                            tail_q <= din;
                        end else begin
                            count_q <= 2'd1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch controller: owns the fetch PC, holds the memory address
// for RD_WAIT cycles, captures the word into a 2-entry queue and hands it to
// decode over valid/ready. Redirect flushes everything and restarts fetch.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int          RD_WAIT  = 1,
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        CLK,
    input  logic        Reset_L,
    input  logic        Enable,
    input  logic        Redirect,
    input  logic [63:0] RedirectPC,
    output logic [63:0] IMemAddress,
    input  logic [31:0] IMemData,
    output logic        InstrValid,
    input  logic        InstrReady,
    output logic [31:0] Instr,
    output logic [63:0] InstrPC,
    output logic        Busy,
    output logic [31:0] FetchCount
);

    fetch_state_e state_q;
    logic [3:0]   cnt_q;
    logic [63:0]  pc_q;
    logic         busy_q;
    logic [31:0]  fetch_count_q;
    logic [31:0]  fetch_count_d;

    logic         q_full;
    logic         q_empty;
    logic         pop;
    logic         wait_done;
    logic         capture;
    logic         full_after_capture;

    assign InstrValid  = !q_empty;
    assign IMemAddress = pc_q;
    assign Busy        = busy_q;
    assign FetchCount  = fetch_count_q;

    // A redirect cancels any same-cycle pop so the flushed head is never counted.
    assign pop       = InstrValid && InstrReady && !Redirect;
    assign wait_done = (cnt_q == 4'(RD_WAIT - 1));
    assign capture   = (state_q == WAIT) && Enable && !Redirect && wait_done;

    // Queue occupancy after this capture reaches two: either one entry stays
    // and one arrives, or a full queue swaps one out for one in.
    assign full_after_capture = (!q_empty && !q_full && !pop) || (q_full && pop);

    assign fetch_count_d = fetch_count_q + (pop ? 32'd1 : 32'd0);

    // Fetch FSM together with the wait counter and the fetch PC.
    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            pc_q    <= RESET_PC;
            busy_q  <= 1'b0;
        end else if (Redirect) begin
            pc_q    <= {RedirectPC[63:2], 2'b00};
            cnt_q   <= 4'd0;
            state_q <= Enable ? WAIT : IDLE;
            busy_q  <= Enable;
        end else begin
            case (state_q)
                IDLE: begin
                    if (Enable && !q_full) begin
                        state_q <= WAIT;
                        cnt_q   <= 4'd0;
                        busy_q  <= 1'b1;
                    end
                end
                WAIT: begin
                    if (!Enable) begin
                        state_q <= IDLE;
                        cnt_q   <= 4'd0;
                        busy_q  <= 1'b0;
                    end else if (wait_done) begin
                        pc_q  <= pc_q + 64'(INSTR_BYTES);
                        cnt_q <= 4'd0;
                        if (full_after_capture) begin
                            state_q <= STALL;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                STALL: begin
                    if (!Enable) begin
                        state_q <= IDLE;
                    end else if (pop) begin
                        state_q <= WAIT;
                        cnt_q   <= 4'd0;
                        busy_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= 4'd0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Count instructions accepted by decode.
    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            fetch_count_q <= 32'd0;
        end else begin
            fetch_count_q <= fetch_count_d;
        end
    end

    fetch_queue u_queue (
        .CLK         (CLK),
        .Reset_L     (Reset_L),
        .push_i      (capture),
        .pop_i       (pop),
        .flush_i     (Redirect),
        .din_instr_i (IMemData),
        .din_pc_i    (pc_q),
        .full_o      (q_full),
        .empty_o     (q_empty),
        .head_instr_o(Instr),
        .head_pc_o   (InstrPC)
    );

endmodule
